// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// State encoding, default widths and flag bit positions.
package alu_seq_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_OPW  = 4;
    localparam int DEF_NREG = 4;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_P = 2;
    localparam int FLG_S = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: NREG x DW, two async read ports, one sync write port.
// Ports: clk, rst (sync, high), we/waddr/wdata write, raddr_a/b -> rdata_a/b.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int NREG = DEF_NREG,
    localparam int RAW = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [RAW-1:0] raddr_a,
    output logic [DW-1:0]  rdata_a,
    input  logic [RAW-1:0] raddr_b,
    output logic [DW-1:0]  rdata_b
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-edge write never leaks in.
    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer driving an external ALU: IDLE -> EXEC -> RESP (op), IDLE -> RESP (load).
// Ports: cmd_* command handshake in, alu_* to/from ALU, res_* result handshake out, busy.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int OPW  = DEF_OPW,
    parameter int NREG = DEF_NREG,
    localparam int RAW = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_load,
    input  logic           cmd_nowb,
    input  logic [OPW-1:0] cmd_op,
    input  logic [RAW-1:0] cmd_dst,
    input  logic [RAW-1:0] cmd_srca,
    input  logic [RAW-1:0] cmd_srcb,
    input  logic [DW-1:0]  cmd_imm,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_d,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_z,
    input  logic           alu_c,
    input  logic           alu_p,
    input  logic           alu_s,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DW-1:0]  res_data,
    output logic [3:0]     res_flags,
    output logic           busy
);

    state_t         r_state;
    state_t         w_next;
    logic [RAW-1:0] r_dst;
    logic           r_nowb;

    logic           w_accept;
    logic           w_we;
    logic [RAW-1:0] w_waddr;
    logic [DW-1:0]  w_wdata;
    logic [DW-1:0]  w_rd_a;
    logic [DW-1:0]  w_rd_b;
    logic [3:0]     w_flags;

    alu_seq_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .raddr_a (cmd_srca),
        .rdata_a (w_rd_a),
        .raddr_b (cmd_srcb),
        .rdata_b (w_rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_we      = 1'b0;
        w_waddr   = r_dst;
        w_wdata   = alu_out;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                w_accept  = cmd_valid;
                if (cmd_valid) begin
                    // Load takes priority over nowb when both are set.
                    if (cmd_load) begin
                        w_we    = 1'b1;
                        w_waddr = cmd_dst;
                        w_wdata = cmd_imm;
                        w_next  = RESP;
                    end else begin
                        w_next  = EXEC;
                    end
                end
            end
            EXEC: begin
                w_we   = !r_nowb;
                w_next = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_flags        = '0;
        w_flags[FLG_Z] = alu_z;
        w_flags[FLG_C] = alu_c;
        w_flags[FLG_P] = alu_p;
        w_flags[FLG_S] = alu_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_d     <= '0;
            res_data  <= '0;
            res_flags <= '0;
            r_dst     <= '0;
            r_nowb    <= 1'b0;
        end else if (w_accept) begin
            r_dst  <= cmd_dst;
            r_nowb <= cmd_nowb;
            if (cmd_load) begin
                res_data <= cmd_imm;
            end else begin
                alu_a <= w_rd_a;
                alu_b <= w_rd_b;
                alu_d <= cmd_op;
            end
        end else if (r_state == EXEC) begin
            res_data  <= alu_out;
            res_flags <= w_flags;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a fixed-value ALU stub.
// Vector table for main flow plus hand sequences for backpressure, sweep and reset.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_load, cmd_nowb;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_d;
    logic       alu_z, alu_c, alu_p, alu_s;
    logic       res_valid, res_ready, busy;
    logic [7:0] res_data;
    logic [3:0] res_flags;

    logic [7:0] stub_out;
    logic [3:0] stub_flg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign alu_out = stub_out;
    assign alu_z   = stub_flg[0];
    assign alu_c   = stub_flg[1];
    assign alu_p   = stub_flg[2];
    assign alu_s   = stub_flg[3];

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_nowb  (cmd_nowb),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_d     (alu_d),
        .alu_out   (alu_out),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .alu_p     (alu_p),
        .alu_s     (alu_s),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flags (res_flags),
        .busy      (busy)
    );

    typedef struct {
        logic       ld;
        logic       nowb;
        logic [3:0] op;
        logic [1:0] dst;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [7:0] imm;
        logic [7:0] sout;
        logic [3:0] sflg;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ed;
        logic [3:0] ef;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v, input string tag);
        stub_out = v.sout;
        stub_flg = v.sflg;
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_load  = v.ld;
        cmd_nowb  = v.nowb;
        cmd_op    = v.op;
        cmd_dst   = v.dst;
        cmd_srca  = v.sa;
        cmd_srcb  = v.sb;
        cmd_imm   = v.imm;
        tick();
        // Scramble command inputs: ALU drive must come from registers only.
        cmd_valid = 1'b0;
        cmd_op    = ~v.op;
        cmd_srca  = ~v.sa;
        cmd_srcb  = ~v.sb;
        if (!v.ld) begin
            chk({tag, " exec alu_a"}, 32'(alu_a), 32'(v.ea));
            chk({tag, " exec alu_b"}, 32'(alu_b), 32'(v.eb));
            chk({tag, " exec alu_d"}, 32'(alu_d), 32'(v.op));
            chk({tag, " exec res_valid"}, 32'(res_valid), 32'd0);
            tick();
        end
        chk({tag, " res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, " res_data"}, 32'(res_data), 32'(v.ed));
        chk({tag, " res_flags"}, 32'(res_flags), 32'(v.ef));
        chk({tag, " resp cmd_ready"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, " drained res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, " drained busy"}, 32'(busy), 32'd0);
    endtask

    vec_t       v;
    logic [7:0] held;

    initial begin
        vt[0] = '{1'b1, 1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 8'hFA, 8'h00, 4'h0, 8'h00, 8'h00, 8'hFA, 4'h0};
        vt[1] = '{1'b1, 1'b0, 4'h0, 2'd1, 2'd0, 2'd0, 8'h63, 8'h00, 4'h0, 8'h00, 8'h00, 8'h63, 4'h0};
        vt[2] = '{1'b0, 1'b0, 4'h0, 2'd2, 2'd0, 2'd1, 8'h00, 8'h5D, 4'h2, 8'hFA, 8'h63, 8'h5D, 4'h2};
        vt[3] = '{1'b0, 1'b1, 4'h1, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 4'h1, 8'hFA, 8'h63, 8'h00, 4'h1};
        vt[4] = '{1'b0, 1'b0, 4'h2, 2'd3, 2'd2, 2'd0, 8'h00, 8'h11, 4'h0, 8'h5D, 8'hFA, 8'h11, 4'h0};
        vt[5] = '{1'b0, 1'b0, 4'h3, 2'd0, 2'd3, 2'd3, 8'h00, 8'h77, 4'h8, 8'h11, 8'h11, 8'h77, 4'h8};
        vt[6] = '{1'b0, 1'b0, 4'h4, 2'd0, 2'd0, 2'd1, 8'h00, 8'h44, 4'h4, 8'h77, 8'h63, 8'h44, 4'h4};
        vt[7] = '{1'b0, 1'b0, 4'h5, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 4'h1, 8'h44, 8'h44, 8'h00, 4'h1};
        vt[8] = '{1'b1, 1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'hC3, 8'h99, 4'hF, 8'h00, 8'h00, 8'hC3, 4'h1};
        vt[9] = '{1'b0, 1'b0, 4'h6, 2'd2, 2'd1, 2'd0, 8'h00, 8'hAA, 4'hF, 8'hC3, 8'h44, 8'hAA, 4'hF};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_nowb  = 1'b0;
        cmd_op    = '0;
        cmd_dst   = '0;
        cmd_srca  = '0;
        cmd_srcb  = '0;
        cmd_imm   = '0;
        res_ready = 1'b0;
        stub_out  = '0;
        stub_flg  = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset res_flags", 32'(res_flags), 32'd0);
        chk("reset alu_d", 32'(alu_d), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset res_data", 32'(res_data), 32'd0);

        for (int i = 0; i < 10; i++) begin
            issue(vt[i], $sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        // Backpressure: result held, new command refused.
        v = '{1'b0, 1'b0, 4'h7, 2'd2, 2'd0, 2'd1, 8'h00, 8'h3C, 4'h2, 8'h44, 8'hC3, 8'h3C, 4'h2};
        issue(v, "hold");
        held = res_data;
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_dst   = 2'd3;
        cmd_imm   = 8'hEE;
        stub_out  = 8'h01;
        stub_flg  = 4'h8;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("hold%0d res_valid", k), 32'(res_valid), 32'd1);
            chk($sformatf("hold%0d res_data", k), 32'(res_data), 32'(held));
            chk($sformatf("hold%0d res_flags", k), 32'(res_flags), 32'h2);
            chk($sformatf("hold%0d cmd_ready", k), 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        drain("hold");
        v = '{1'b0, 1'b1, 4'h8, 2'd0, 2'd3, 2'd2, 8'h00, 8'h00, 4'h0, 8'h11, 8'h3C, 8'h00, 4'h0};
        issue(v, "r3 intact");
        drain("r3 intact");

        // Opcode sweep, no write-back; regs r0=0x44 r1=0xC3.
        for (int op = 0; op < 16; op++) begin
            v = '{1'b0, 1'b1, 4'(op), 2'd2, 2'd0, 2'd1, 8'h00, 8'(op + 16),
                  4'(op), 8'h44, 8'hC3, 8'(op + 16), 4'(op)};
            issue(v, $sformatf("sweep%0d", op));
            drain($sformatf("sweep%0d", op));
        end

        // Reset during EXEC aborts the command.
        stub_out  = 8'h99;
        stub_flg  = 4'h6;
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_nowb  = 1'b0;
        cmd_op    = 4'h9;
        cmd_dst   = 2'd2;
        cmd_srca  = 2'd1;
        cmd_srcb  = 2'd0;
        tick();
        cmd_valid = 1'b0;
        chk("abort in exec busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort res_valid", 32'(res_valid), 32'd0);
        chk("abort res_data", 32'(res_data), 32'd0);
        chk("abort res_flags", 32'(res_flags), 32'd0);
        chk("abort alu_a", 32'(alu_a), 32'd0);
        tick();
        chk("abort stays idle", 32'(res_valid), 32'd0);
        v = '{1'b0, 1'b1, 4'hA, 2'd0, 2'd2, 2'd1, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0};
        issue(v, "post abort");
        drain("post abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
